// File: rtl/core_req_sequencer_if.sv
// Bundled command / core / response signals of core_req_sequencer.
// master = the sequencer itself, slave = its environment (upstream, core, downstream).
interface core_req_sequencer_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_mode;
   logic [9:0]  cmd_data_1;
   logic [2:0]  cmd_data_2;
   logic        core_in_valid;
   logic        core_in_mode;
   logic [9:0]  core_in_data_1;
   logic [2:0]  core_in_data_2;
   logic        core_out_valid;
   logic [19:0] core_out_data;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [19:0] rsp_data;
   logic        rsp_mode;
   logic        rsp_timeout;
   logic [7:0]  stale_cnt;

   modport master (
      input  cmd_valid, cmd_mode, cmd_data_1, cmd_data_2,
      input  core_out_valid, core_out_data, rsp_ready,
      output cmd_ready, core_in_valid, core_in_mode, core_in_data_1, core_in_data_2,
      output rsp_valid, rsp_data, rsp_mode, rsp_timeout, stale_cnt
   );

   modport slave (
      output cmd_valid, cmd_mode, cmd_data_1, cmd_data_2,
      output core_out_valid, core_out_data, rsp_ready,
      input  cmd_ready, core_in_valid, core_in_mode, core_in_data_1, core_in_data_2,
      input  rsp_valid, rsp_data, rsp_mode, rsp_timeout, stale_cnt
   );
endinterface

// File: rtl/core_req_sequencer.sv
// core_req_sequencer: accepts one command, pulses it into the division/root core,
// holds mode/operands until the result is captured, returns it on a valid/ready port.
// Optional watchdog enabled by defining CORE_REQ_SEQ_TIMEOUT_EN; without it WAIT
// only exits on a core result and rsp_timeout is tied low.
module core_req_sequencer #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input logic                  clk,
   input logic                  rst,
   core_req_sequencer_if.master bus
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("core_req_sequencer: TIMEOUT_CYCLES must be within 2..255");
   end

   logic [1:0]  state_q, state_d;
   logic        in_valid_q, in_valid_d;
   logic        mode_q, mode_d;
   logic [9:0]  data_1_q, data_1_d;
   logic [2:0]  data_2_q, data_2_d;
   logic [19:0] rsp_data_q, rsp_data_d;
   logic [7:0]  stale_q, stale_d;

`ifdef CORE_REQ_SEQ_TIMEOUT_EN
   // Expiry fires on the WAIT cycle whose increment would reach TIMEOUT_CYCLES-1,
   // so RESP starts exactly TIMEOUT_CYCLES cycles after the ISSUE cycle.
   localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 2);
   logic [7:0] wd_q, wd_d;
   logic       timeout_q, timeout_d;
`endif

   // Next-state, operand latch, result capture and stale counting
   always_comb begin
      state_d    = state_q;
      in_valid_d = 1'b0;
      mode_d     = mode_q;
      data_1_d   = data_1_q;
      data_2_d   = data_2_q;
      rsp_data_d = rsp_data_q;
      stale_d    = stale_q;
`ifdef CORE_REQ_SEQ_TIMEOUT_EN
      wd_d       = wd_q;
      timeout_d  = timeout_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               mode_d     = bus.cmd_mode;
               data_1_d   = bus.cmd_data_1;
               data_2_d   = bus.cmd_data_2;
               in_valid_d = 1'b1;
               state_d    = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
`ifdef CORE_REQ_SEQ_TIMEOUT_EN
            wd_d    = 8'd0;
`endif
         end
         S_WAIT: begin
            // A result on the expiry cycle takes priority over the timeout
            if (bus.core_out_valid) begin
               rsp_data_d = bus.core_out_data;
               state_d    = S_RESP;
`ifdef CORE_REQ_SEQ_TIMEOUT_EN
               timeout_d  = 1'b0;
            end else if (wd_q == WD_LAST) begin
               rsp_data_d = 20'hFFFFF;
               timeout_d  = 1'b1;
               state_d    = S_RESP;
            end else begin
               wd_d = wd_q + 8'd1;
`endif
            end
         end
         S_RESP: begin
            if (bus.rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (bus.core_out_valid && state_q != S_WAIT && stale_q != 8'hFF)
         stale_d = stale_q + 8'd1;
   end

   // State and datapath registers, asynchronously cleared
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         in_valid_q <= 1'b0;
         mode_q     <= 1'b0;
         data_1_q   <= 10'd0;
         data_2_q   <= 3'd0;
         rsp_data_q <= 20'd0;
         stale_q    <= 8'd0;
`ifdef CORE_REQ_SEQ_TIMEOUT_EN
         wd_q       <= 8'd0;
         timeout_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         in_valid_q <= in_valid_d;
         mode_q     <= mode_d;
         data_1_q   <= data_1_d;
         data_2_q   <= data_2_d;
         rsp_data_q <= rsp_data_d;
         stale_q    <= stale_d;
`ifdef CORE_REQ_SEQ_TIMEOUT_EN
         wd_q       <= wd_d;
         timeout_q  <= timeout_d;
`endif
      end
   end

   assign bus.cmd_ready      = (state_q == S_IDLE);
   assign bus.rsp_valid      = (state_q == S_RESP);
   assign bus.core_in_valid  = in_valid_q;
   assign bus.core_in_mode   = mode_q;
   assign bus.core_in_data_1 = data_1_q;
   assign bus.core_in_data_2 = data_2_q;
   assign bus.rsp_data       = rsp_data_q;
   assign bus.rsp_mode       = mode_q;
   assign bus.stale_cnt      = stale_q;
`ifdef CORE_REQ_SEQ_TIMEOUT_EN
   assign bus.rsp_timeout    = timeout_q;
`else
   assign bus.rsp_timeout    = 1'b0;
`endif

endmodule
